// File: rtl/mem_arbiter.sv
// Round-robin multi-port arbiter that serialises 1/2/4-byte requests into byte beats on an 8-bit bus.
// Optional `MEM_ARB_IO_STALL_EN holds IO-space write beats while io_buffer_full is set.
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [2*NUM_PORTS-1:0]      req_len,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        resp_done,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        busy,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [31:0]                 mem_a,
  output logic                        mem_wr,
  input  logic                        io_buffer_full
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_port;
  logic [2:0]          r_len;
  logic [2:0]          r_step;
  logic                r_replay;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_gnt_hit;
  logic [PW-1:0]       w_gnt_port;
  logic [1:0]          w_gnt_len;
  logic [2:0]          w_gnt_bytes;
  logic [2:0]          w_off;
  logic [ADDR_W-1:0]   w_beat_addr;
  logic [1:0]          w_cap_idx;
  logic                w_io_hold;
  logic                w_adv;

  // First pending port strictly after the last granted one.
  always_comb begin
    // NOTE: every comb output gets a default first, so no latch can be inferred.
    w_gnt_hit  = 1'b0;
    w_gnt_port = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!w_gnt_hit && req_valid[(int'(r_ptr) + i) % NUM_PORTS]) begin
        w_gnt_hit  = 1'b1;
        w_gnt_port = PW'((int'(r_ptr) + i) % NUM_PORTS);
      end
    end
  end

  assign w_gnt_len = req_len[2*w_gnt_port +: 2];

  always_comb begin
    case (w_gnt_len)
      2'd0:    w_gnt_bytes = 3'd1;
      2'd1:    w_gnt_bytes = 3'd2;
      default: w_gnt_bytes = 3'd4;
    endcase
  end

  // After a pause in RD the previous byte's address is replayed, since its return was lost.
  assign w_off       = r_replay ? (r_step - 3'd1) : r_step;
  assign w_beat_addr = r_addr + ADDR_W'(w_off);
  assign w_cap_idx   = 2'(r_step - 3'd1);

`ifdef MEM_ARB_IO_STALL_EN
  assign w_io_hold = (r_state == S_WR) && (w_beat_addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic w_unused_io_full;
  assign w_unused_io_full = io_buffer_full;
  assign w_io_hold        = 1'b0;
`endif

  assign w_adv = rdy_in && !w_io_hold;

  always_comb begin
    w_next     = r_state;
    resp_done  = '0;
    resp_rdata = '0;
    busy       = 1'b0;
    mem_dout   = 8'h00;
    mem_a      = 32'h0;
    mem_wr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rdy_in && w_gnt_hit)
          w_next = req_we[w_gnt_port] ? S_WR : S_RD;
      end
      S_RD: begin
        busy = 1'b1;
        if ((r_step < r_len) || r_replay)
          mem_a = 32'(w_beat_addr);
        if (rdy_in && !r_replay && (r_step == r_len))
          w_next = S_DONE;
      end
      S_WR: begin
        busy     = 1'b1;
        mem_a    = 32'(w_beat_addr);
        mem_dout = r_wdata[8*r_step[1:0] +: 8];
        mem_wr   = w_adv;
        if (w_adv && (r_step == r_len - 3'd1))
          w_next = S_DONE;
      end
      S_DONE: begin
        busy              = 1'b1;
        resp_rdata        = r_rdata;
        resp_done[r_port] = rdy_in;
        if (rdy_in)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_ptr    <= PW'(NUM_PORTS - 1);
      r_port   <= '0;
      r_len    <= 3'd1;
      r_step   <= 3'd0;
      r_replay <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_state <= w_next;
      if (rdy_in) begin
        case (r_state)
          S_IDLE: begin
            if (w_gnt_hit) begin
              r_ptr    <= w_gnt_port;
              r_port   <= w_gnt_port;
              r_len    <= w_gnt_bytes;
              r_step   <= 3'd0;
              r_replay <= 1'b0;
              r_addr   <= req_addr[ADDR_W*w_gnt_port +: ADDR_W];
              r_wdata  <= req_wdata[DATA_W*w_gnt_port +: DATA_W];
              r_rdata  <= '0;
            end
          end
          S_RD: begin
            if (r_replay) begin
              r_replay <= 1'b0;
            end else begin
              if (r_step != 3'd0)
                r_rdata[8*w_cap_idx +: 8] <= mem_din;
              if (r_step != r_len)
                r_step <= r_step + 3'd1;
            end
          end
          S_WR: begin
            if (!w_io_hold)
              r_step <= r_step + 3'd1;
          end
          default: ;
        endcase
      end else if ((r_state == S_RD) && (r_step != 3'd0)) begin
        r_replay <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_we = '0;
  logic [2*N-1:0]   req_len = '0;
  logic [32*N-1:0]  req_addr = '0;
  logic [32*N-1:0]  req_wdata = '0;
  logic [N-1:0]     resp_done;
  logic [31:0]      resp_rdata;
  logic             busy;
  logic [7:0]       mem_din = 8'h00;
  logic [7:0]       mem_dout;
  logic [31:0]      mem_a;
  logic             mem_wr;
  logic             io_full = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_arbiter #(.NUM_PORTS(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .rdy_in         (rdy),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_len        (req_len),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_done      (resp_done),
    .resp_rdata     (resp_rdata),
    .busy           (busy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus memory: sparse image, untouched bytes read as addr[7:0]^5A, data returned one cycle later.
  logic [7:0] mem_img [logic [31:0]];

  function automatic logic [7:0] img_rd(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    mem_din <= img_rd(mem_a);
    if (mem_wr) mem_img[mem_a] = mem_dout;
  end

  function automatic bit io_stalls(input logic [31:0] a);
`ifdef MEM_ARB_IO_STALL_EN
    return (a[17:16] == 2'b11) && io_full;
`else
    return (a[17:16] == 2'b11) && 1'b0;
`endif
  endfunction

  // Reference model: one transaction at a time, counting bytes moved rather than FSM steps.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_phase   = M_IDLE;
  int          m_ptr     = N - 1;
  int          m_port    = 0;
  bit          m_we      = 1'b0;
  logic [31:0] m_addr    = '0;
  int          m_len     = 1;
  logic [31:0] m_wdata   = '0;
  logic [31:0] m_exp_rd  = '0;
  int          m_moved   = 0;
  bit          m_inflight = 1'b0;

  always @(negedge clk) begin : model
    logic [N-1:0] e_done;
    logic [31:0]  e_a;
    logic [7:0]   e_dout;
    logic         e_wr;
    logic         e_busy;
    bit           chk_a;
    bit           chk_rd;
    if (rst) begin
      check("reset_outputs", {resp_done, resp_rdata, busy, mem_dout, mem_a, mem_wr}, '0);
      m_phase    = M_IDLE;
      m_ptr      = N - 1;
      m_inflight = 1'b0;
    end else begin
      e_done = '0; e_a = '0; e_dout = '0; e_wr = 1'b0; e_busy = 1'b0;
      chk_a = 1'b1; chk_rd = 1'b0;
      case (m_phase)
        M_IDLE: begin
          if (rdy && (|req_valid)) begin
            for (int i = 1; i <= N; i++) begin
              int p;
              p = (m_ptr + i) % N;
              if (m_phase == M_IDLE && req_valid[p]) begin
                m_port   = p;
                m_phase  = M_BUSY;
              end
            end
            m_ptr      = m_port;
            m_we       = req_we[m_port];
            m_addr     = req_addr[32*m_port +: 32];
            m_wdata    = req_wdata[32*m_port +: 32];
            m_len      = (req_len[2*m_port +: 2] == 2'd0) ? 1 :
                         (req_len[2*m_port +: 2] == 2'd1) ? 2 : 4;
            m_exp_rd   = '0;
            for (int b = 0; b < m_len; b++)
              m_exp_rd = m_exp_rd | (32'(img_rd(m_addr + 32'(b))) << (8*b));
            m_moved    = 0;
            m_inflight = 1'b0;
          end
        end
        M_BUSY: begin
          e_busy = 1'b1;
          if (!m_we) begin
            if (!rdy) begin
              chk_a      = 1'b0;
              m_inflight = 1'b0;
            end else begin
              if (m_inflight) m_moved++;
              if (m_moved < m_len) begin
                e_a        = m_addr + 32'(m_moved);
                m_inflight = 1'b1;
              end else begin
                m_inflight = 1'b0;
                m_phase    = M_DONE;
              end
            end
          end else begin
            if (!rdy || io_stalls(m_addr + 32'(m_moved))) begin
              chk_a = 1'b0;
            end else begin
              e_wr   = 1'b1;
              e_a    = m_addr + 32'(m_moved);
              e_dout = m_wdata[8*m_moved +: 8];
              m_moved++;
              if (m_moved == m_len) m_phase = M_DONE;
            end
          end
        end
        M_DONE: begin
          e_busy = 1'b1;
          chk_rd = !m_we;
          if (rdy) begin
            e_done[m_port] = 1'b1;
            m_phase        = M_IDLE;
          end
        end
        default: m_phase = M_IDLE;
      endcase
      check("busy", busy, e_busy);
      check("mem_wr", mem_wr, e_wr);
      check("resp_done", resp_done, e_done);
      if (chk_a) begin
        check("mem_a", mem_a, e_a);
        check("mem_dout", mem_dout, e_dout);
      end
      if (chk_rd) check("resp_rdata", resp_rdata, m_exp_rd);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit we, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] d);
    req_we[p]            = we;
    req_len[2*p +: 2]    = len;
    req_addr[32*p +: 32] = a;
    req_wdata[32*p +: 32] = d;
    req_valid[p]         = 1'b1;
  endtask

  // Waits for port p's done pulse, then releases its request in the following idle cycle.
  task automatic wait_done(input int p, input int budget, output int dcyc, output logic [31:0] rd);
    dcyc = -1;
    rd   = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (resp_done[p]) begin
        dcyc = cyc;
        rd   = resp_rdata;
        break;
      end
    end
    check("done_within_budget", dcyc >= 0, 1'b1);
    tick(1);
    req_valid[p] = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t;
    int d;
    int order [4];
    logic [31:0] rds [4];
    logic [31:0] rd;
    int n_done;
    int n_abort;

    mem_img[32'h104] = 8'h11;
    mem_img[32'h105] = 8'h22;
    mem_img[32'h106] = 8'h33;
    mem_img[32'h107] = 8'h44;

    // Reset state
    tick(2);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", resp_done, '0);
    check("reset_mem_a", mem_a, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // 4-byte read, port 1
    set_req(1, 1'b0, 2'd2, 32'h0000_0104, 32'h0);
    t = cyc;
    wait_done(1, 30, d, rd);
    check("rd4_latency", d - t, 6);
    check("rd4_rdata", rd, 32'h4433_2211);

    // 2-byte write across a 64K boundary, port 0
    set_req(0, 1'b1, 2'd1, 32'h0001_FFFF, 32'h0000_BEEF);
    t = cyc;
    @(negedge clk);
    @(negedge clk);
    check("wr_beat0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0001_FFFF, 8'hEF});
    @(negedge clk);
    check("wr_beat1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0002_0000, 8'hBE});
    wait_done(0, 30, d, rd);
    check("wr2_latency", d - t, 3);
    check("wr2_mem", {img_rd(32'h0001_FFFF), img_rd(32'h0002_0000)}, 16'hEFBE);

    // Round-robin with both ports continuously pending, from reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    set_req(0, 1'b0, 2'd0, 32'h0000_0104, 32'h0);
    set_req(1, 1'b0, 2'd0, 32'h0000_0106, 32'h0);
    n_done = 0;
    for (int i = 0; i < 60 && n_done < 4; i++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++)
        if (resp_done[p] && n_done < 4) begin
          order[n_done] = p;
          rds[n_done]   = resp_rdata;
          n_done++;
        end
    end
    check("rr_done_count", n_done, 4);
    tick(1);
    req_valid = '0;
    check("rr_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_01_00_01);
    check("rr_rdata", {rds[0], rds[1], rds[2], rds[3]}, {32'h11, 32'h33, 32'h11, 32'h33});
    tick(1);

    // Pause for 2 cycles at step 2 of a 4-byte read
    set_req(1, 1'b0, 2'd2, 32'h0000_0104, 32'h0);
    t = cyc;
    tick(3);
    rdy = 1'b0;
    @(negedge clk);
    check("pause_no_wr", mem_wr, 1'b0);
    tick(2);
    rdy = 1'b1;
    @(negedge clk);
    check("pause_replay_addr", mem_a, 32'h0000_0105);
    wait_done(1, 30, d, rd);
    check("pause_latency", d - t, 9);
    check("pause_rdata", rd, 32'h4433_2211);

    // Reset in the middle of a read aborts it silently
    set_req(1, 1'b0, 2'd2, 32'h0000_0200, 32'h0);
    tick(3);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("abort_outputs", {resp_done, busy, mem_wr, mem_a}, '0);
    tick(1);
    rst = 1'b0;
    n_abort = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (|resp_done) n_abort++;
    end
    check("abort_no_done", n_abort, 0);
    tick(1);
    set_req(0, 1'b0, 2'd1, 32'h0000_0105, 32'h0);
    t = cyc;
    wait_done(0, 30, d, rd);
    check("post_abort_latency", d - t, 4);
    check("post_abort_rdata", rd, 32'h0000_3322);

    // Address wraps modulo 2^32 (untouched bytes read as addr[7:0]^5A)
    set_req(1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
    t = cyc;
    wait_done(1, 30, d, rd);
    check("wrap_latency", d - t, 4);
    check("wrap_rdata", rd, 32'h0000_5AA5);

    // IO-space 1-byte write with the UART buffer full for 3 cycles
    set_req(0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
    io_full = 1'b1;
    t = cyc;
    @(negedge clk);
    @(negedge clk);
`ifdef MEM_ARB_IO_STALL_EN
    check("io_stall_first", mem_wr, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    io_full = 1'b0;
    wait_done(0, 30, d, rd);
    check("io_latency", d - t, 5);
`else
    check("io_nostall_beat", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0000, 8'h41});
    wait_done(0, 30, d, rd);
    io_full = 1'b0;
    check("io_latency", d - t, 2);
`endif
    check("io_mem", img_rd(32'h0003_0000), 8'h41);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
